// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display: one shared
// BCD decoder, blanking guard between digits, display data swapped only at frame wrap.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic [7:0]                seg,
    output logic                      frame_done
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                    r_state;
    logic                      r_active;
    logic [IDX_W-1:0]          r_idx;
    logic [CNT_W-1:0]          r_cnt;
    logic [4*NUM_DIGITS-1:0]   r_pend_bcd;
    logic [NUM_DIGITS-1:0]     r_pend_dp;
    logic [4*NUM_DIGITS-1:0]   r_shadow_bcd;
    logic [NUM_DIGITS-1:0]     r_shadow_dp;
    logic [NUM_DIGITS-1:0]     r_digit_sel;
    logic [7:0]                r_seg;
    logic                      r_frame_done;

    logic [3:0]                w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     w_upper_zero;
    logic [NUM_DIGITS-1:0]     w_sel_lit;
    logic [3:0]                w_nib_cur;
    logic                      w_dp_cur;
    logic                      w_suppress;
    logic [7:0]                w_dec;
    logic [7:0]                w_seg_lit;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi]     = r_shadow_bcd[gi*4 +: 4];
            assign w_sel_lit[gi] = (r_idx != IDX_W'(gi));
        end
    endgenerate

    // w_upper_zero[k]: nibble k and every more-significant nibble are zero
    always_comb begin
        w_upper_zero = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            for (int j = k; j < NUM_DIGITS; j++) begin
                if (w_nib[j] != 4'd0) begin
                    w_upper_zero[k] = 1'b0;
                end
            end
        end
    end

    assign w_nib_cur  = w_nib[r_idx];
    assign w_dp_cur   = r_shadow_dp[r_idx];
    assign w_suppress = blank_lz && (r_idx != '0) && w_upper_zero[r_idx];

    always_comb begin
        w_dec = 8'hFF;
        case (w_nib_cur)
            4'd0: w_dec = 8'h03;
            4'd1: w_dec = 8'h9F;
            4'd2: w_dec = 8'h25;
            4'd3: w_dec = 8'h0D;
            4'd4: w_dec = 8'h99;
            4'd5: w_dec = 8'h49;
            4'd6: w_dec = 8'h41;
            4'd7: w_dec = 8'h1F;
            4'd8: w_dec = 8'h01;
            4'd9: w_dec = 8'h09;
            default: w_dec = 8'hFF;
        endcase
    end

    always_comb begin
        w_seg_lit = 8'hFF;
        if (w_nib_cur <= 4'd9) begin
            if (w_suppress) begin
                w_seg_lit = {7'h7F, ~w_dp_cur};
            end else begin
                w_seg_lit = {w_dec[7:1], ~w_dp_cur};
            end
        end
    end

    // Outputs are registered alongside the state, so idx/shadow are unchanged
    // on any edge that enters ON and the decode above applies to the new state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_active     <= 1'b0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_pend_bcd   <= '0;
            r_pend_dp    <= '0;
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_digit_sel  <= '1;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (load) begin
                r_pend_bcd <= bcd_in;
                r_pend_dp  <= dp_in;
            end

            if (!en || !r_active) begin
                // Idle, or the first enabled edge which opens a fresh blank phase
                r_active    <= en;
                r_state     <= ST_BLANK;
                r_idx       <= '0;
                r_cnt       <= '0;
                r_digit_sel <= '1;
                r_seg       <= 8'hFF;
            end else begin
                case (r_state)
                    ST_BLANK: begin
                        if (r_cnt == BLANK_LAST) begin
                            r_state     <= ST_ON;
                            r_cnt       <= '0;
                            r_digit_sel <= w_sel_lit;
                            r_seg       <= w_seg_lit;
                        end else begin
                            r_cnt       <= r_cnt + CNT_W'(1);
                            r_digit_sel <= '1;
                            r_seg       <= 8'hFF;
                        end
                    end
                    ST_ON: begin
                        if (r_cnt == DIGIT_LAST) begin
                            r_state     <= ST_BLANK;
                            r_cnt       <= '0;
                            r_digit_sel <= '1;
                            r_seg       <= 8'hFF;
                            if (r_idx == IDX_LAST) begin
                                r_idx        <= '0;
                                r_frame_done <= 1'b1;
                                if (load) begin
                                    r_shadow_bcd <= bcd_in;
                                    r_shadow_dp  <= dp_in;
                                end else begin
                                    r_shadow_bcd <= r_pend_bcd;
                                    r_shadow_dp  <= r_pend_dp;
                                end
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign digit_sel  = r_digit_sel;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: each scenario queues the per-cycle expected
// display, and run_check pops one entry per clock and compares it to the outputs.
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int DC = 4;
    localparam int BC = 1;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         load;
    logic [15:0]  bcd_in;
    logic [3:0]   dp_in;
    logic         blank_lz;
    logic [3:0]   digit_sel;
    logic [7:0]   seg;
    logic         frame_done;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .digit_sel (digit_sel),
        .seg       (seg),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [7:0] ref_seg(input logic [15:0] bcd, input logic [3:0] dp,
                                           input logic lz, input int k);
        logic [3:0] nib;
        logic [7:0] pat;
        logic       upper;
        nib   = bcd[k*4 +: 4];
        upper = 1'b1;
        for (int j = k; j < N; j++) begin
            if (bcd[j*4 +: 4] != 4'd0) upper = 1'b0;
        end
        case (nib)
            4'd0: pat = 8'h03;
            4'd1: pat = 8'h9F;
            4'd2: pat = 8'h25;
            4'd3: pat = 8'h0D;
            4'd4: pat = 8'h99;
            4'd5: pat = 8'h49;
            4'd6: pat = 8'h41;
            4'd7: pat = 8'h1F;
            4'd8: pat = 8'h01;
            4'd9: pat = 8'h09;
            default: pat = 8'hFF;
        endcase
        if (nib > 4'd9) return 8'hFF;
        if (lz && (k != 0) && upper) return {7'h7F, ~dp[k]};
        return {pat[7:1], ~dp[k]};
    endfunction

    task automatic push_blank();
        exp_t e;
        e.sel = 4'hF;
        e.seg = 8'hFF;
        e.fd  = 1'b0;
        exp_q.push_back(e);
    endtask

    // One full frame: blank + DC lit cycles per digit, digit 0 first
    task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp,
                              input logic lz, input logic fd);
        exp_t e;
        for (int d = 0; d < N; d++) begin
            e.sel = 4'hF;
            e.seg = 8'hFF;
            e.fd  = fd && (d == 0);
            exp_q.push_back(e);
            for (int c = 0; c < DC; c++) begin
                e.sel    = 4'hF;
                e.sel[d] = 1'b0;
                e.seg    = ref_seg(bcd, dp, lz, d);
                e.fd     = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_check(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s underflow cyc=%0d got sel=%b seg=%h fd=%b required=none",
                         tag, cyc, digit_sel, seg, frame_done);
            end else begin
                e = exp_q.pop_front();
                total += 3;
                if (digit_sel !== e.sel) begin
                    bad++;
                    $display("FAIL %s digit_sel cyc=%0d got=%b required=%b", tag, cyc, digit_sel, e.sel);
                end
                if (seg !== e.seg) begin
                    bad++;
                    $display("FAIL %s seg cyc=%0d got=%h required=%h", tag, cyc, seg, e.seg);
                end
                if (frame_done !== e.fd) begin
                    bad++;
                    $display("FAIL %s frame_done cyc=%0d got=%b required=%b", tag, cyc, frame_done, e.fd);
                end
            end
        end
        $display("checked %s: %0d cycles, errors so far %0d", tag, n, bad);
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        load   = 1'b1;
        bcd_in = b;
        dp_in  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total += 3;
        if (digit_sel !== 4'hF) begin
            bad++;
            $display("FAIL reset digit_sel got=%b required=1111", digit_sel);
        end
        if (seg !== 8'hFF) begin
            bad++;
            $display("FAIL reset seg got=%h required=ff", seg);
        end
        if (frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset frame_done got=%b required=0", frame_done);
        end
        $display("checked reset: errors so far %0d", bad);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_scan();
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
        run_check("scan_first_frame", 20);
    endtask

    task automatic test_load_boundary();
        push_frame(16'h0000, 4'h0, 1'b0, 1'b1);
        run_check("lb_before", 10);
        do_load(16'h1234, 4'b0010);
        run_check("lb_load", 1);
        load = 1'b0;
        run_check("lb_after", 9);
        push_frame(16'h1234, 4'b0010, 1'b0, 1'b1);
        run_check("lb_new_frame", 20);
    endtask

    task automatic test_back_to_back();
        push_frame(16'h1234, 4'b0010, 1'b0, 1'b1);
        run_check("bb_hold", 5);
        do_load(16'h0009, 4'h0);
        run_check("bb_load9", 1);
        load = 1'b0;
        run_check("bb_gap", 1);
        do_load(16'h0008, 4'h0);
        run_check("bb_load8", 1);
        load = 1'b0;
        run_check("bb_rest", 12);
        push_frame(16'h0008, 4'h0, 1'b0, 1'b1);
        run_check("bb_overwrite", 20);
        // load sampled on the wrap edge itself
        do_load(16'h4321, 4'b0001);
        push_frame(16'h4321, 4'b0001, 1'b0, 1'b1);
        run_check("wrap_load", 1);
        load = 1'b0;
        run_check("wrap_frame", 19);
        push_frame(16'h4321, 4'b0001, 1'b0, 1'b1);
        run_check("wrap_pend_kept", 20);
    endtask

    task automatic test_lz();
        blank_lz = 1'b1;
        push_frame(16'h4321, 4'b0001, 1'b1, 1'b1);
        run_check("lz_pre", 10);
        do_load(16'h0070, 4'h0);
        run_check("lz_load", 1);
        load = 1'b0;
        run_check("lz_pre_rest", 9);
        push_frame(16'h0070, 4'h0, 1'b1, 1'b1);
        run_check("lz_on", 20);
        blank_lz = 1'b0;
        push_frame(16'h0070, 4'h0, 1'b0, 1'b1);
        run_check("lz_off", 20);
    endtask

    task automatic test_invalid_en();
        push_frame(16'h0070, 4'h0, 1'b0, 1'b1);
        run_check("inv_pre", 10);
        do_load(16'hF005, 4'h0);
        run_check("inv_load", 1);
        load = 1'b0;
        run_check("inv_pre_rest", 9);
        push_frame(16'hF005, 4'h0, 1'b0, 1'b1);
        run_check("inv_to_digit2", 12);
        exp_q.delete();
        en = 1'b0;
        repeat (3) push_blank();
        run_check("en_low", 3);
        en = 1'b1;
        push_frame(16'hF005, 4'h0, 1'b0, 1'b0);
        run_check("en_restart", 20);
    endtask

    task automatic test_mid_reset();
        push_frame(16'hF005, 4'h0, 1'b0, 1'b1);
        run_check("mr_to_digit1", 8);
        exp_q.delete();
        rst_n = 1'b0;
        push_blank();
        run_check("mr_reset_edge", 1);
        rst_n = 1'b1;
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
        run_check("mr_restart", 20);
        push_frame(16'h0000, 4'h0, 1'b0, 1'b1);
        run_check("mr_pend_cleared", 20);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        bcd_in   = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_load_boundary();
        test_back_to_back();
        test_lz();
        test_invalid_en();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
